load_store_unit: RTL and testbench

Memory-access stage of the RV32I core. It sits directly downstream of the ALU: it consumes the ALU result as the effective address (rs1 + imm) and rs2 as store data. It runs one load or store per request over a single-outstanding req/ready data-bus handshake, and returns a sign/zero-extended load value to writeback. A control FSM starts it and stalls on `busy` until the one-cycle `done` pulse.

---
 rtl/load_store_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit -- memory-access stage of the RV32I core.
//
// Runs one load or store per request over a single-outstanding req/ready
// data bus, then returns the sign- or zero-extended load value to writeback.
// Control starts it with `start` and stalls while `busy` until the one-cycle
// `done` pulse.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses skip the bus and complete
//               in cycle 1 with done = fault = 1 and load_data = 0.
//   undefined : fault is tied 0 and misaligned addresses are force-aligned.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request strobe, sampled only in IDLE
//   isLoad, isStore   request type (exactly one must be set to be accepted)
//   funct3            access size / sign
//   addr              effective byte address
//   store_data        rs2 value
//   busy, done, fault status to control (fault valid with done)
//   load_data         extended load result, held until the next load done
//   mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata   bus request side
//   mem_rdata, mem_ready                             bus response side
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isLoad,
    input  logic             isStore,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] load_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Undefined funct3 encodings fall through to word accesses.
    function automatic logic [1:0] access_size(input logic is_store, input logic [2:0] f3);
        logic [1:0] sz;
        if (is_store) begin
            case (f3)
                3'b000:  sz = SZ_BYTE;
                3'b001:  sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b100: sz = SZ_BYTE;
                3'b001, 3'b101: sz = SZ_HALF;
                default:        sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    // Halfword lanes only look at off[1], so addr[0] is ignored (force-align).
    function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] s;
        case (sz)
            SZ_BYTE: s = 4'b0001 << off;
            SZ_HALF: s = 4'b0011 << {off[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] store_lanes(input logic [1:0] sz, input logic [WIDTH-1:0] sd);
        logic [WIDTH-1:0] w;
        case (sz)
            SZ_BYTE: w = {4{sd[7:0]}};
            SZ_HALF: w = {2{sd[15:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] load_extract(input logic [1:0] sz, input logic unsgn,
                                                      input logic [1:0] off, input logic [WIDTH-1:0] rd);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WIDTH-1:0] r;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_BYTE: r = unsgn ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = unsgn ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             misalign_s;
    logic [1:0]       req_size_s;
    logic [1:0]       rsp_size_s;
    logic             busy_next_s;
    logic             req_next_s;
    logic             done_next_s;

    logic             busy_r;
    logic             done_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [WIDTH-1:0] mem_addr_r;
    logic [3:0]       mem_wstrb_r;
    logic [WIDTH-1:0] mem_wdata_r;
    logic [WIDTH-1:0] load_data_r;
    logic [1:0]       addr_lo_r;
    logic [2:0]       funct3_r;

    assign accept_s   = (state_r == ST_IDLE) && start && (isLoad ^ isStore);
    assign req_size_s = access_size(isStore, funct3);
    assign rsp_size_s = access_size(mem_we_r, funct3_r);

`ifdef LSU_MISALIGN_CHECK_EN
    logic fault_r;

    assign misalign_s = ((req_size_s == SZ_HALF) && addr[0]) ||
                        ((req_size_s == SZ_WORD) && (addr[1:0] != 2'b00));

    // Fault flag: set on a misaligned accept, cleared once its RESP cycle passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (accept_s) begin
            fault_r <= misalign_s;
        end else if (state_r == ST_RESP) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;
`else
    assign misalign_s = 1'b0;
    assign fault      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; ACCESS waits on mem_ready with no timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = misalign_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Status outputs are registered, so they are decoded from the next state.
    always_comb begin
        busy_next_s = (state_next_s != ST_IDLE);
        req_next_s  = (state_next_s == ST_ACCESS);
        done_next_s = (state_next_s == ST_RESP);
    end

    // Output and request-latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {WIDTH{1'b0}};
            mem_wstrb_r <= 4'b0000;
            mem_wdata_r <= {WIDTH{1'b0}};
            load_data_r <= {WIDTH{1'b0}};
            addr_lo_r   <= 2'b00;
            funct3_r    <= 3'b000;
        end else begin
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            mem_req_r <= req_next_s;
            if (accept_s) begin
                mem_we_r    <= isStore;
                mem_addr_r  <= {addr[WIDTH-1:2], 2'b00};
                mem_wstrb_r <= isStore ? store_strb(req_size_s, addr[1:0]) : 4'b0000;
                mem_wdata_r <= isStore ? store_lanes(req_size_s, store_data) : {WIDTH{1'b0}};
                addr_lo_r   <= addr[1:0];
                funct3_r    <= funct3;
                if (misalign_s) begin
                    load_data_r <= {WIDTH{1'b0}};
                end else begin
                    load_data_r <= load_data_r;
                end
            end else if ((state_r == ST_ACCESS) && mem_ready && !mem_we_r) begin
                // funct3[2] marks the unsigned loads (LBU/LHU).
                load_data_r <= load_extract(rsp_size_s, funct3_r[2], addr_lo_r, mem_rdata);
            end else begin
                load_data_r <= load_data_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign load_data = load_data_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wstrb = mem_wstrb_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        bit          ld;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        bit          mis;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        isLoad;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks   = 0;
    int failures = 0;
    vec_t exp_q[$];
    vec_t vecs[16];

    load_store_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .isLoad(isLoad), .isStore(isStore),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .fault(fault), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                input logic [31:0] ea, input logic [3:0] es,
                                input logic [31:0] ew, input logic [31:0] el, input bit mis);
        vec_t v;
        v.ld = ld; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rd;
        v.exp_addr = ea; v.exp_strb = es; v.exp_wdata = ew; v.exp_load = el; v.mis = mis;
        return v;
    endfunction

    // One request from start to the cycle after done, with wait_n ready-low cycles.
    task automatic run_op(input vec_t v, input int wait_n, input bit poke_start);
        vec_t e;
        bit   exp_fault;
        exp_fault = MIS_EN && v.mis;
        @(negedge clk);
        start = 1'b1; isLoad = v.ld; isStore = !v.ld; funct3 = v.f3;
        addr = v.addr; store_data = v.sd;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0; isLoad = 1'b0; isStore = 1'b0;
        addr = $urandom; store_data = $urandom;
        chk("busy_c1", {31'd0, busy}, 32'd1);
        if (exp_fault) begin
            chk("req_fault", {31'd0, mem_req}, 32'd0);
            chk("done_fault", {31'd0, done}, 32'd1);
        end else begin
            chk("req_c1", {31'd0, mem_req}, 32'd1);
            chk("done_c1", {31'd0, done}, 32'd0);
            chk("mem_addr", mem_addr, v.exp_addr);
            chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.exp_strb});
            chk("mem_we", {31'd0, mem_we}, {31'd0, !v.ld});
            if (!v.ld) chk("mem_wdata", mem_wdata, v.exp_wdata);
            for (int i = 0; i < wait_n; i++) begin
                if (poke_start) begin
                    start = 1'b1; isLoad = 1'b1; isStore = 1'b0; funct3 = 3'b010;
                    addr = 32'h0000_0ABC;
                end
                @(negedge clk);
                start = 1'b0; isLoad = 1'b0;
                chk("req_wait", {31'd0, mem_req}, 32'd1);
                chk("done_wait", {31'd0, done}, 32'd0);
                chk("addr_stable", mem_addr, v.exp_addr);
                chk("strb_stable", {28'd0, mem_wstrb}, {28'd0, v.exp_strb});
                if (!v.ld) chk("wdata_stable", mem_wdata, v.exp_wdata);
            end
            mem_rdata = v.rdata; mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0; mem_rdata = $urandom;
            chk("done", {31'd0, done}, 32'd1);
            chk("req_drop", {31'd0, mem_req}, 32'd0);
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("fault", {31'd0, fault}, {31'd0, exp_fault});
            if (e.ld) chk("load_data", load_data, exp_fault ? 32'd0 : e.exp_load);
        end
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; isLoad = 1'b0; isStore = 1'b0; funct3 = 3'b000;
        addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;

        //          ld    f3      addr          sd            rdata         exp_addr      strb     wdata         load          mis
        vecs[0]  = mk(1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0);
        vecs[1]  = mk(1'b1, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0);
        vecs[2]  = mk(1'b1, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 1'b0);
        vecs[3]  = mk(1'b1, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_80FF, 1'b0);
        vecs[4]  = mk(1'b1, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_1234, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_80FF, 1'b0);
        vecs[5]  = mk(1'b1, 3'b000, 32'h0000_0100, 32'h0,        32'h80FF_1234, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0034, 1'b0);
        vecs[6]  = mk(1'b1, 3'b001, 32'h0000_0100, 32'h0,        32'h80FF_9234, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_9234, 1'b0);
        vecs[7]  = mk(1'b0, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,       32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0);
        vecs[8]  = mk(1'b0, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,       32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0,        1'b0);
        vecs[9]  = mk(1'b0, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,       32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
        vecs[10] = mk(1'b1, 3'b010, 32'h0000_0102, 32'h0,        32'h1122_3344, 32'h0000_0100, 4'b0000, 32'h0,        32'h1122_3344, 1'b1);
        vecs[11] = mk(1'b1, 3'b011, 32'h0000_0104, 32'h0,        32'h5566_7788, 32'h0000_0104, 4'b0000, 32'h0,        32'h5566_7788, 1'b0);
        vecs[12] = mk(1'b0, 3'b000, 32'h0000_0203, 32'h1234_5678, 32'h0,       32'h0000_0200, 4'b1000, 32'h7878_7878, 32'h0,        1'b0);
        vecs[13] = mk(1'b1, 3'b001, 32'h0000_0101, 32'h0,        32'hA5A5_8001, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b1);
        vecs[14] = mk(1'b0, 3'b111, 32'h0000_0208, 32'h0BAD_F00D, 32'h0,       32'h0000_0208, 4'b1111, 32'h0BAD_F00D, 32'h0,        1'b0);
        vecs[15] = mk(1'b0, 3'b010, 32'h0000_0301, 32'h8765_4321, 32'h0,       32'h0000_0300, 4'b1111, 32'h8765_4321, 32'h0,        1'b1);

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // start with both type bits equal is ignored
        @(negedge clk);
        start = 1'b1; isLoad = 1'b1; isStore = 1'b1; addr = 32'h0000_0500;
        @(negedge clk);
        start = 1'b0; isLoad = 1'b0; isStore = 1'b0;
        chk("both_ignored_busy", {31'd0, busy}, 32'd0);
        chk("both_ignored_req", {31'd0, mem_req}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i], i % 3, 1'b0);
        end

        // SW held off 3 cycles, with a start poked in while busy
        run_op(mk(1'b0, 3'b010, 32'h0000_0400, 32'h1357_9BDF, 32'h0, 32'h0000_0400,
                  4'b1111, 32'h1357_9BDF, 32'h0, 1'b0), 3, 1'b1);

        // reset in the second ACCESS cycle abandons the request
        @(negedge clk);
        start = 1'b1; isLoad = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h0000_0600;
        @(negedge clk);
        start = 1'b0; isLoad = 1'b0;
        chk("rst_acc_req_c1", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        chk("rst_acc_req_c2", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_acc_req", {31'd0, mem_req}, 32'd0);
        chk("rst_acc_busy", {31'd0, busy}, 32'd0);
        chk("rst_acc_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("rst_acc_no_done", {31'd0, done}, 32'd0);

        run_op(mk(1'b1, 3'b010, 32'h0000_0700, 32'h0, 32'h2468_ACE0, 32'h0000_0700,
                  4'b0000, 32'h0, 32'h2468_ACE0, 1'b0), 1, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
